// File: rtl/video_timing.sv
// video_timing: raster counters with registered sync/DE/EOF/SOL outputs.
// Ports: clk, reset (async, active-high), pix_en_i in; h_count_o, v_count_o,
//   hsync_o, vsync_o, de_o, eof_o, sol_o out.
// Macro VIDEO_TIMING_SOL_EN enables the start-of-line pulse on sol_o.
module video_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en_i,
  output logic [HW-1:0] h_count_o,
  output logic [VW-1:0] v_count_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          eof_o,
  output logic          sol_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic          r_eof;

  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_h_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_de_nxt;
  logic          w_eof_nxt;

  // Outputs are decoded from the next counter values so that the
  // registered flags line up with the counters they describe.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
    w_v_nxt  = r_v;
    if (w_h_wrap) begin
      w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end
    w_hs_act  = (w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END);
    w_vs_act  = (w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END);
    w_de_nxt  = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    w_eof_nxt = (w_h_nxt == '0) && (w_v_nxt == V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_hsync <= ~H_SYNC_POL;
      r_vsync <= ~V_SYNC_POL;
      r_de    <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      // EOF drops after one clk even if the counters stall on (0, V_VISIBLE).
      r_eof <= 1'b0;
      if (pix_en_i) begin
        r_h     <= w_h_nxt;
        r_v     <= w_v_nxt;
        r_hsync <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
        r_vsync <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
        r_de    <= w_de_nxt;
        r_eof   <= w_eof_nxt;
      end
    end
  end

`ifdef VIDEO_TIMING_SOL_EN
  logic r_sol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sol <= 1'b0;
    end else begin
      r_sol <= pix_en_i && w_h_wrap;
    end
  end

  assign sol_o = r_sol;
`else
  assign sol_o = 1'b0;
`endif

  assign h_count_o = r_h;
  assign v_count_o = r_v;
  assign hsync_o   = r_hsync;
  assign vsync_o   = r_vsync;
  assign de_o      = r_de;
  assign eof_o     = r_eof;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: random pixel-enable stimulus against a position model.
// Small-raster DUT for whole frames, default-parameter DUT for first lines.
module tb_video_timing;

  localparam int HT = 16;
  localparam int VV = 6;
  localparam int FT = 176;
  localparam int DHT = 800;
  localparam int DFT = 420000;
`ifdef VIDEO_TIMING_SOL_EN
  localparam bit SOL_ON = 1'b1;
`else
  localparam bit SOL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] h, v;
  logic       hs, vs, de, eof, sol;
  logic [9:0] dh, dv;
  logic       dhs, dvs, dde, deof, dsol;

  int n_chk = 0;
  int n_pass = 0;
  int cnt = 0;
  int dcnt = 0;
  bit stepped = 0;
  bit dstepped = 0;
  bit exp_eof = 0;
  bit exp_sol = 0;
  bit dexp_eof = 0;
  bit dexp_sol = 0;
  int cyc = 0;
  int last_eof = -1;
  int period_exp = 0;

  always #5 clk = ~clk;

  video_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en_i(en),
    .h_count_o(h), .v_count_o(v),
    .hsync_o(hs), .vsync_o(vs), .de_o(de),
    .eof_o(eof), .sol_o(sol)
  );

  video_timing u_def (
    .clk(clk), .reset(reset), .pix_en_i(1'b1),
    .h_count_o(dh), .v_count_o(dv),
    .hsync_o(dhs), .vsync_o(dvs), .de_o(dde),
    .eof_o(deof), .sol_o(dsol)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic bit sync_exp(int c, int lo, int w, bit pol);
    return (c >= lo && c < lo + w) ? pol : !pol;
  endfunction

  task automatic check_small();
    int hh = cnt % HT;
    int vv = cnt / HT;
    check("h", h, hh);
    check("v", v, vv);
    check("hsync", hs, sync_exp(hh, 10, 3, 1'b1));
    check("vsync", vs, sync_exp(vv, 7, 2, 1'b0));
    check("de", de, stepped && hh < 8 && vv < VV);
    check("eof", eof, exp_eof);
    check("sol", sol, exp_sol);
  endtask

  task automatic check_def();
    int hh = dcnt % DHT;
    int vv = dcnt / DHT;
    check("d_h", dh, hh);
    check("d_v", dv, vv);
    check("d_hsync", dhs, sync_exp(hh, 656, 96, 1'b0));
    check("d_vsync", dvs, sync_exp(vv, 490, 2, 1'b0));
    check("d_de", dde, dstepped && hh < 640 && vv < 480);
    check("d_eof", deof, dexp_eof);
    check("d_sol", dsol, dexp_sol);
  endtask

  task automatic tick(input bit nxt_en);
    @(posedge clk);
    exp_eof = 0; exp_sol = 0;
    dexp_eof = 0; dexp_sol = 0;
    if (!reset) begin
      if (en) begin
        cnt = (cnt + 1) % FT;
        stepped = 1;
        exp_eof = (cnt == VV * HT);
        exp_sol = SOL_ON && (cnt % HT == 0);
      end
      dcnt = (dcnt + 1) % DFT;
      dstepped = 1;
      dexp_eof = (dcnt == 480 * DHT);
      dexp_sol = SOL_ON && (dcnt % DHT == 0);
    end
    @(negedge clk);
    cyc++;
    check_small();
    check_def();
    if (eof) begin
      if (period_exp != 0 && last_eof >= 0)
        check("eof_period", cyc - last_eof, period_exp);
      last_eof = cyc;
    end
    en = nxt_en;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cnt = 0; dcnt = 0;
    stepped = 0; dstepped = 0;
    exp_eof = 0; exp_sol = 0;
    dexp_eof = 0; dexp_sol = 0;
    last_eof = -1;
    check_small();
    check_def();
    repeat (hold) tick(1'($urandom_range(0, 1)));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check_small();
    check_def();
    reset = 1'b0;

    period_exp = FT;
    last_eof = -1;
    repeat (2 * FT + 20) tick(1'b1);

    en = 1'b0;
    period_exp = 2 * FT;
    last_eof = -1;
    for (int i = 0; i < 4 * FT + 20; i++) tick(i[0]);

    period_exp = 0;
    repeat (600) tick(1'($urandom_range(0, 3) != 0));

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(10, 150)) tick(1'($urandom_range(0, 3) != 0));
      do_reset(5);
    end

    repeat (1700) tick(1'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter H_SYNC_POL / V_SYNC_POL, defaults 0 / 0, active level of each sync output.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pix_en_i  input  1  pixel-advance enable; counters step only on cycles where it is 1.
REQ-009 h_count_o  output  $clog2(H_TOTAL)  current pixel column, H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK.
REQ-010 v_count_o  output  $clog2(V_TOTAL)  current line, V_TOTAL defined likewise.
REQ-011 hsync_o / vsync_o  output  1 each  sync outputs at the configured polarity.
REQ-012 de_o  output  1  display-enable, high while in the visible area.
REQ-013 eof_o  output  1  end-of-frame pulse; this is the eof_i input of the frame-driven test/writer stage.
REQ-014 sol_o  output  1  start-of-line pulse (see Configuration).

Function
REQ-015 On an enabled cycle, h_count SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_count SHALL increment.
REQ-016 At (H_TOTAL-1, V_TOTAL-1), both counters SHALL wrap to 0 on the same enabled cycle.
REQ-017 On a cycle with pix_en_i=0, counters and hsync_o/vsync_o/de_o SHALL hold.
REQ-018 Line order: visible, front porch, sync, back porch; the frame uses the same order.
REQ-019 hsync_o SHALL be at H_SYNC_POL exactly while h_count_o is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; otherwise at its inverse.
REQ-020 vsync_o SHALL follow the same rule using v_count_o and the vertical parameters.
REQ-021 de_o SHALL be 1 exactly while h_count_o<H_VISIBLE and v_count_o<V_VISIBLE.
REQ-022 hsync_o/vsync_o/de_o SHALL be registered and SHALL correspond to the h_count_o/v_count_o values presented in the same cycle, with zero cycles of skew.
REQ-023 eof_o SHALL be 1 for exactly one clk, in the cycle where the counters first read (0, V_VISIBLE); while pix_en_i holds there, it SHALL NOT re-assert.
REQ-024 Exactly one eof_o pulse per frame; no pulse in the first partial frame after reset before (0, V_VISIBLE) is reached.
REQ-025 Counter arithmetic SHALL never yield values ≥ H_TOTAL or ≥ V_TOTAL.

Reset
REQ-026 While reset=1: counters=0, de_o=0, eof_o=0, sol_o=0, hsync_o=~H_SYNC_POL, vsync_o=~V_SYNC_POL, applied asynchronously.
REQ-027 After reset deasserts, the first enabled cycle SHALL advance h_count_o to 1.
REQ-028 Reset mid-frame SHALL abandon the frame with no eof_o pulse generated.

Configuration
REQ-029 Macro VIDEO_TIMING_SOL_EN defined: sol_o SHALL pulse for one clk in the cycle where h_count_o first reads 0, for every line including blanking lines.
REQ-030 Macro VIDEO_TIMING_SOL_EN undefined: sol_o SHALL be constant 0 and its logic SHALL be absent.

Verification
REQ-031 Defaults, pix_en_i=1, run 2 frames -> eof_o pulses exactly 420000 clks apart (800×525).
REQ-032 Defaults, single line -> hsync_o low for h_count 656..751 (96 clks) and high elsewhere; de_o high for h_count 0..639 on lines 0..479.
REQ-033 Defaults -> vsync_o low for lines 490..491 only; de_o never high on lines 480..524.
REQ-034 pix_en_i toggled 1,0,1,0… -> eof_o period 840000 clks; eof_o width still 1 clk; no counter change on 0 cycles.
REQ-035 Reset asserted at (h=300, v=200), released 5 clks later -> counters 0, syncs inactive immediately, no eof_o before (0,480).
REQ-036 VIDEO_TIMING_SOL_EN defined -> 525 sol_o pulses per frame, 800 clks apart; undefined -> sol_o stays 0.
